// File: rtl/sdr_dec_pkg.sv
// Shared types and constants for the passive SDRAM command decoder.
package sdr_dec_pkg;

  localparam int NUM_BANKS = 4;
  localparam int CNT_W     = 4;   // elapsed-cycle counters; timing limits must stay below 2**CNT_W

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6,
    CMD_BST = 3'd7
  } sdr_cmd_e;

  typedef enum logic [2:0] {
    INIT_PRE,
    INIT_REF1,
    INIT_REF2,
    INIT_MRS,
    INIT_DONE
  } sdr_init_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] PIN_MRS = 4'b0000;
  localparam logic [3:0] PIN_REF = 4'b0001;
  localparam logic [3:0] PIN_PRE = 4'b0010;
  localparam logic [3:0] PIN_ACT = 4'b0011;
  localparam logic [3:0] PIN_WR  = 4'b0100;
  localparam logic [3:0] PIN_RD  = 4'b0101;
  localparam logic [3:0] PIN_BST = 4'b0110;
  localparam logic [3:0] PIN_NOP = 4'b0111;

  // Device-side view of the command pins; a deasserted cke or cs_n is a NOP.
  function automatic sdr_cmd_e decode_pins(input logic cke, input logic [3:0] pins);
    sdr_cmd_e cmd;
    cmd = CMD_NOP;
    if (cke) begin
      case (pins)
        PIN_ACT: cmd = CMD_ACT;
        PIN_RD:  cmd = CMD_RD;
        PIN_WR:  cmd = CMD_WR;
        PIN_PRE: cmd = CMD_PRE;
        PIN_REF: cmd = CMD_REF;
        PIN_MRS: cmd = CMD_MRS;
        PIN_BST: cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

  // Elapsed-cycle counter step that parks at its limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/sdr_bank_tracker.sv
// Per-bank open/row state with ACT and PRE elapsed counters and bank-level checks.
module sdr_bank_tracker
  import sdr_dec_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act_i,        // ACT addressed to this bank
  input  logic        rdwr_i,       // RD or WR addressed to this bank
  input  logic        close_i,      // PRE / PRE-all / auto-precharge hitting this bank
  input  logic [12:0] row_i,
  output logic        open_o,
  output logic [12:0] row_o,
  output logic        err_trcd_o,
  output logic        err_trp_o,
  output logic        err_closed_o,
  output logic        err_open_o
);

  localparam logic [CNT_W-1:0] TRCD_L = CNT_W'(TRCD);
  localparam logic [CNT_W-1:0] TRP_L  = CNT_W'(TRP);

  logic             open_q, open_d;
  logic [12:0]      row_q, row_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;

  // Checks compare the current command against elapsed counts before this edge updates them.
  assign err_trcd_o   = rdwr_i && (act_cnt_q < TRCD_L);
  assign err_closed_o = rdwr_i && !open_q;
  assign err_trp_o    = act_i  && (pre_cnt_q < TRP_L);
  assign err_open_o   = act_i  && open_q;
  assign open_o       = open_q;
  assign row_o        = row_q;

  // Next bank state: a restarted counter reads 1 on the following cycle, i.e. elapsed = k.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    open_d    = open_q;
    row_d     = row_q;
    act_cnt_d = sat_inc(act_cnt_q, TRCD_L);
    pre_cnt_d = sat_inc(pre_cnt_q, TRP_L);
    if (act_i) begin
      open_d    = 1'b1;
      row_d     = row_i;
      act_cnt_d = CNT_W'(1);
    end
    if (close_i) begin
      open_d    = 1'b0;
      pre_cnt_d = CNT_W'(1);
    end
  end

  // Bank state registers; counters come out of reset saturated so nothing fires spuriously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q    <= 1'b0;
      row_q     <= '0;
      act_cnt_q <= TRCD_L;
      pre_cnt_q <= TRP_L;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      open_q    <= open_d;
      row_q     <= row_d;
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/sdr_cmd_decoder.sv
// Passive SDRAM command decoder and protocol checker: decode, tMRD, init FSM, error aggregation.
module sdr_cmd_decoder
  import sdr_dec_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3,
  parameter int TMRD = 2
) (
  input  logic        sdram_clk,
  input  logic        wb_rst_i,
  input  logic        sdr_cke,
  input  logic        sdr_cs_n,
  input  logic        sdr_ras_n,
  input  logic        sdr_cas_n,
  input  logic        sdr_we_n,
  input  logic [1:0]  sdr_ba,
  input  logic [12:0] sdr_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [1:0]  cmd_ba,
  output logic [12:0] cmd_row,
  output logic [3:0]  bank_open,
  output logic [12:0] mode_reg,
  output logic        init_done,
  output logic        err_trcd,
  output logic        err_trp,
  output logic        err_tmrd,
  output logic        err_closed,
  output logic        err_open,
  output logic [7:0]  err_cnt
);

  localparam logic [CNT_W-1:0] TMRD_L = CNT_W'(TMRD);

  sdr_cmd_e cmd;
  logic     valid, a10, is_rdwr, any_open;

  logic [NUM_BANKS-1:0] act_b, rdwr_b, close_b, open_b;
  logic [NUM_BANKS-1:0] trcd_b, trp_b, closed_b, open_err_b;
  logic [12:0]          row_b [NUM_BANKS];

  assign cmd      = decode_pins(sdr_cke, {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n});
  assign valid    = (cmd != CMD_NOP);
  assign a10      = sdr_addr[10];
  assign is_rdwr  = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign any_open = |open_b;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign act_b[i]   = (cmd == CMD_ACT) && (sdr_ba == 2'(i));
    assign rdwr_b[i]  = is_rdwr && (sdr_ba == 2'(i));
    assign close_b[i] = ((cmd == CMD_PRE) && (a10 || (sdr_ba == 2'(i)))) || (rdwr_b[i] && a10);

    sdr_bank_tracker #(.TRCD(TRCD), .TRP(TRP)) u_bank (
      .clk          (sdram_clk),
      .rst          (wb_rst_i),
      .act_i        (act_b[i]),
      .rdwr_i       (rdwr_b[i]),
      .close_i      (close_b[i]),
      .row_i        (sdr_addr),
      .open_o       (open_b[i]),
      .row_o        (row_b[i]),
      .err_trcd_o   (trcd_b[i]),
      .err_trp_o    (trp_b[i]),
      .err_closed_o (closed_b[i]),
      .err_open_o   (open_err_b[i])
    );
  end

  assign bank_open = open_b;

  logic             cmd_valid_q, cmd_valid_d;
  sdr_cmd_e         cmd_code_q, cmd_code_d;
  logic [1:0]       cmd_ba_q, cmd_ba_d;
  logic [12:0]      cmd_row_q, cmd_row_d;
  logic [12:0]      mode_reg_q, mode_reg_d;
  logic [4:0]       err_q, err_d;        // {trcd, trp, tmrd, closed, open}
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] mrd_cnt_q, mrd_cnt_d;
  logic [8:0]       err_sum;
  sdr_init_e        state_q, state_d;

  // Command decode, error aggregation and saturating error count.
  always_comb begin
    cmd_valid_d = valid;
    cmd_code_d  = cmd;
    cmd_ba_d    = valid ? sdr_ba : 2'd0;
    cmd_row_d   = '0;
    mode_reg_d  = mode_reg_q;
    mrd_cnt_d   = sat_inc(mrd_cnt_q, TMRD_L);
    case (cmd)
      CMD_ACT:        cmd_row_d = sdr_addr;
      CMD_RD, CMD_WR: cmd_row_d = row_b[sdr_ba];
      CMD_MRS: begin
        mode_reg_d = sdr_addr;
        mrd_cnt_d  = CNT_W'(1);
      end
      default: ;
    endcase
    err_d[4] = |trcd_b;
    err_d[3] = |trp_b;
    err_d[2] = valid && (mrd_cnt_q < TMRD_L);
    err_d[1] = |closed_b;
    err_d[0] = (|open_err_b) || (((cmd == CMD_REF) || (cmd == CMD_MRS)) && any_open);
    err_sum  = {1'b0, err_cnt_q} + 9'(err_d[4]) + 9'(err_d[3]) + 9'(err_d[2])
             + 9'(err_d[1]) + 9'(err_d[0]);
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Initialization sequence next state; DONE holds until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_PRE:  if (cmd == CMD_PRE && a10) state_d = INIT_REF1;
      INIT_REF1: if (cmd == CMD_REF)        state_d = INIT_REF2;
      INIT_REF2: if (cmd == CMD_REF)        state_d = INIT_MRS;
      INIT_MRS:  if (cmd == CMD_MRS)        state_d = INIT_DONE;
      default:                              state_d = state_q;
    endcase
  end

  // Output, tMRD and init-state registers.
  always_ff @(posedge sdram_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      mode_reg_q  <= '0;
      err_q       <= '0;
      err_cnt_q   <= '0;
      mrd_cnt_q   <= TMRD_L;
      state_q     <= INIT_PRE;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_row_q   <= cmd_row_d;
      mode_reg_q  <= mode_reg_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      mrd_cnt_q   <= mrd_cnt_d;
      state_q     <= state_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_ba     = cmd_ba_q;
  assign cmd_row    = cmd_row_q;
  assign mode_reg   = mode_reg_q;
  assign init_done  = (state_q == INIT_DONE);
  assign err_trcd   = err_q[4];
  assign err_trp    = err_q[3];
  assign err_tmrd   = err_q[2];
  assign err_closed = err_q[1];
  assign err_open   = err_q[0];
  assign err_cnt    = err_cnt_q;

endmodule
